// File: rtl/sha256_msg_padder_if.sv
// Byte-stream input and padded-block output bundle for the SHA-256 message padder.
// The master modport is the padder's view; the slave modport is the view of its environment.
interface sha256_msg_padder_if;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         err_ovf;

    modport master (
        input  in_valid, in_data, in_last, blk_ready,
        output in_ready, blk_valid, blk_data, blk_first, blk_last, err_ovf
    );

    modport slave (
        output in_valid, in_data, in_last, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_first, blk_last, err_ovf
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// Collects a byte stream into 512-bit blocks and applies SHA-256 padding
// (0x80 marker, zero fill, 64-bit big-endian bit length) ahead of the hash core.
module sha256_msg_padder #(
    parameter int MAX_BYTES = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    sha256_msg_padder_if.master bus
);
    localparam int CNT_W = $clog2(MAX_BYTES + 1) + 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES * 8);

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_EMIT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [511:0]     blk_buf;
    logic [511:0]     pad_buf;
    logic [5:0]       idx;
    logic [CNT_W-1:0] bit_cnt;
    logic             msg_done;
    logic             marker_done;
    logic             final_blk;
    logic             first_pending;
    logic             ovf;
    logic             cnt_full;
    logic             in_ready_c;
    logic             blk_valid_c;
    logic             in_ready_o;
    logic             blk_valid_o;
    logic             byte_acc;
    logic             blk_acc;

    function automatic logic [63:0] len_field(input logic [CNT_W-1:0] bits);
        return 64'(bits);
    endfunction

    function automatic logic [511:0] put_byte(input logic [511:0] b,
                                              input logic [5:0]   pos,
                                              input logic [7:0]   v);
        logic [511:0] r;
        r = b;
        for (int i = 0; i < 64; i++) begin
            if (6'(i) == pos) r[511-8*i -: 8] = v;
        end
        return r;
    endfunction

    assign cnt_full = (bit_cnt >= CNT_MAX);

    // Outputs are forced low while reset is held, independent of state.
    assign in_ready_o    = rst_n & in_ready_c;
    assign blk_valid_o   = rst_n & blk_valid_c;
    assign byte_acc      = bus.in_valid & in_ready_o;
    assign blk_acc       = blk_valid_o & bus.blk_ready;
    assign bus.in_ready  = in_ready_o;
    assign bus.blk_valid = blk_valid_o;
    assign bus.blk_data  = blk_valid_o ? blk_buf : '0;
    assign bus.blk_first = blk_valid_o & first_pending;
    assign bus.blk_last  = blk_valid_o & final_blk;
    assign bus.err_ovf   = rst_n & ovf;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FILL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        blk_valid_c = 1'b0;
        case (state)
            S_FILL: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    if (!cnt_full) begin
                        if (idx == 6'd63)     state_nxt = S_EMIT;
                        else if (bus.in_last) state_nxt = S_PAD;
                    end else if (bus.in_last) begin
                        state_nxt = S_PAD;
                    end
                end
            end
            S_PAD: state_nxt = S_EMIT;
            S_EMIT: begin
                blk_valid_c = 1'b1;
                if (bus.blk_ready) begin
                    if (final_blk)     state_nxt = S_FILL;
                    else if (msg_done) state_nxt = S_PAD;
                    else               state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    // Padding image: marker after the held bytes, or an all-zero length block
    // when the marker already went out in the previous block.
    always_comb begin
        pad_buf = '0;
        if (!marker_done) begin
            for (int i = 0; i < 64; i++) begin
                if (6'(i) < idx)       pad_buf[511-8*i -: 8] = blk_buf[511-8*i -: 8];
                else if (6'(i) == idx) pad_buf[511-8*i -: 8] = 8'h80;
            end
            if (idx <= 6'd55) pad_buf[63:0] = len_field(bit_cnt);
        end else begin
            pad_buf[63:0] = len_field(bit_cnt);
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx           <= '0;
            bit_cnt       <= '0;
            msg_done      <= 1'b0;
            marker_done   <= 1'b0;
            final_blk     <= 1'b0;
            first_pending <= 1'b1;
            ovf           <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (byte_acc) begin
                        if (!cnt_full) begin
                            idx     <= idx + 6'd1;
                            bit_cnt <= bit_cnt + CNT_W'(8);
                            if (bus.in_last) msg_done <= 1'b1;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    if (!marker_done) begin
                        marker_done <= 1'b1;
                        if (idx <= 6'd55) final_blk <= 1'b1;
                    end else begin
                        final_blk <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (blk_acc) begin
                        idx           <= '0;
                        first_pending <= 1'b0;
                        if (final_blk) begin
                            msg_done      <= 1'b0;
                            marker_done   <= 1'b0;
                            final_blk     <= 1'b0;
                            bit_cnt       <= '0;
                            ovf           <= 1'b0;
                            first_pending <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Block buffer; stale contents never leak because padding copies only bytes below idx.
    always_ff @(posedge clk) begin
        case (state)
            S_FILL: if (byte_acc && !cnt_full) blk_buf <= put_byte(blk_buf, idx, bus.in_data);
            S_PAD:  blk_buf <= pad_buf;
            S_EMIT: if (blk_acc) blk_buf <= '0;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: random messages against a padding model built by
// appending marker, zeros and length to the kept bytes, plus directed boundary cases.
module tb_sha256_msg_padder;
    localparam int MAX_BYTES = 128;

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blk_t;

    logic clk;
    logic rst_n;
    int   n_total = 0;
    int   n_pass = 0;
    int   ready_mode = 1;
    int   m_cnt = 0;
    logic m_ovf = 1'b0;
    blk_t exp_q[$];
    blk_t model_out[$];
    logic [7:0] msg[$];
    logic [511:0] held;

    sha256_msg_padder_if bus ();

    sha256_msg_padder #(.MAX_BYTES(MAX_BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    endtask

    task automatic timeout(input string name);
        check(name, 512'(0), 512'(1));
        finish_run();
    endtask

    // Reference: keep at most MAX_BYTES bytes, append 0x80, zero-fill to 56 mod 64, append bit length.
    function automatic void build_model(input logic [7:0] m[$]);
        logic [7:0]  p[$];
        logic [63:0] bits;
        int          kept;
        int          nb;
        blk_t        b;
        model_out.delete();
        kept = (m.size() > MAX_BYTES) ? MAX_BYTES : m.size();
        for (int i = 0; i < kept; i++) p.push_back(m[i]);
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(kept) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        nb = p.size() / 64;
        for (int bi = 0; bi < nb; bi++) begin
            b.data = '0;
            for (int j = 0; j < 64; j++) b.data[511-8*j -: 8] = p[64*bi+j];
            b.first = (bi == 0);
            b.last  = (bi == nb - 1);
            model_out.push_back(b);
        end
    endfunction

    // Sink: drives blk_ready just after each rising edge.
    initial begin
        bus.blk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.blk_ready = ($urandom_range(0, 2) != 0);
                1:       bus.blk_ready = 1'b1;
                default: bus.blk_ready = 1'b0;
            endcase
        end
    end

    // Compare process: every falling edge, outputs against the scoreboard and err_ovf model.
    initial begin
        blk_t f;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_ctrl", 512'({bus.in_ready, bus.blk_valid, bus.blk_first,
                                        bus.blk_last, bus.err_ovf}), 512'(0));
                check("rst_data", bus.blk_data, 512'(0));
                m_cnt = 0;
                m_ovf = 1'b0;
            end else begin
                check("err_ovf", 512'(bus.err_ovf), 512'(m_ovf));
                if (bus.blk_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_blk", 512'(bus.blk_valid), 512'(0));
                    end else begin
                        f = exp_q[0];
                        check("blk_data", bus.blk_data, f.data);
                        check("blk_flags", 512'({bus.blk_first, bus.blk_last}),
                              512'({f.first, f.last}));
                        check("in_ready_in_emit", 512'(bus.in_ready), 512'(0));
                        if (bus.blk_ready) begin
                            if (f.last) begin
                                m_ovf = 1'b0;
                                m_cnt = 0;
                            end
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    m_cnt++;
                    if (m_cnt > MAX_BYTES) m_ovf = 1'b1;
                end
            end
        end
    end

    task automatic send_msg(input logic [7:0] m[$], input bit abort);
        int n;
        int waited;
        int lat;
        int exp_lat;
        n = m.size();
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = m[i];
            bus.in_last  = !abort && (i == n - 1);
            waited = 0;
            @(negedge clk);
            while (!bus.in_ready) begin
                waited++;
                if (waited > 1000) timeout("in_ready_wait");
                @(negedge clk);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!abort) begin
            exp_lat = (n > MAX_BYTES || n % 64 != 0) ? 2 : 1;
            lat = 0;
            while (lat < 8) begin
                @(negedge clk);
                lat++;
                if (bus.blk_valid) break;
            end
            check("latency", 512'(lat), 512'(exp_lat));
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            w++;
            if (w > 2000) timeout("drain");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_msg(input logic [7:0] m[$]);
        build_model(m);
        foreach (model_out[i]) exp_q.push_back(model_out[i]);
        send_msg(m, 1'b0);
        drain();
    endtask

    initial begin
        int lens[15] = '{1, 3, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128, 129, 130, 200};
        int w;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 512'({bus.in_ready, bus.blk_valid}), 512'(2'b10));

        // "abc": single block
        msg = '{8'h61, 8'h62, 8'h63};
        build_model(msg);
        check("pin_abc_n", 512'(model_out.size()), 512'(1));
        check("pin_abc", model_out[0].data, {32'h61626380, 416'h0, 64'h18});
        check("pin_abc_flags", 512'({model_out[0].first, model_out[0].last}), 512'(2'b11));
        ready_mode = 0;
        run_msg(msg);

        // 56 zero bytes: marker in block 1, length-only block 2
        msg.delete();
        for (int i = 0; i < 56; i++) msg.push_back(8'h00);
        build_model(msg);
        check("pin_z56_n", 512'(model_out.size()), 512'(2));
        check("pin_z56_b1", model_out[0].data, {448'h0, 8'h80, 56'h0});
        check("pin_z56_b2", model_out[1].data, {448'h0, 64'h1C0});
        run_msg(msg);

        // 64 bytes of 0xFF: full block, then marker + length block
        msg.delete();
        for (int i = 0; i < 64; i++) msg.push_back(8'hFF);
        build_model(msg);
        check("pin_ff64_b1", model_out[0].data, {512{1'b1}});
        check("pin_ff64_b2", model_out[1].data, {8'h80, 440'h0, 64'h200});
        run_msg(msg);

        // 130 bytes: two discarded, length capped at 1024 bits
        msg.delete();
        for (int i = 0; i < 130; i++) msg.push_back(8'($urandom));
        build_model(msg);
        check("pin_ovf_n", 512'(model_out.size()), 512'(3));
        check("pin_ovf_len", 512'(model_out[2].data[63:0]), 512'(64'h400));
        check("pin_ovf_mark", 512'(model_out[2].data[511:504]), 512'(8'h80));
        run_msg(msg);

        // Backpressure on "abc"
        msg = '{8'h61, 8'h62, 8'h63};
        build_model(msg);
        foreach (model_out[i]) exp_q.push_back(model_out[i]);
        ready_mode = 2;
        send_msg(msg, 1'b0);
        held = bus.blk_data;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 512'({bus.blk_valid, bus.in_ready}), 512'(2'b10));
            check("bp_stable", bus.blk_data, held);
        end
        ready_mode = 1;
        w = 0;
        @(negedge clk);
        while (!bus.blk_ready) begin
            w++;
            if (w > 5) timeout("bp_release");
            @(negedge clk);
        end
        @(negedge clk);
        check("bp_after", 512'({bus.blk_valid, bus.in_ready}), 512'(2'b01));
        drain();

        // Reset mid-message: nothing may be emitted, next message starts clean
        msg.delete();
        for (int i = 0; i < 10; i++) msg.push_back(8'($urandom));
        send_msg(msg, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        repeat (4) @(negedge clk);
        check("abort_idle", 512'({bus.blk_valid, bus.in_ready}), 512'(2'b01));
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(msg);

        // Random messages with random gaps and backpressure
        ready_mode = 0;
        for (int t = 0; t < 21; t++) begin
            int n;
            n = (t < 15) ? lens[t] : $urandom_range(1, 140);
            msg.delete();
            for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
            run_msg(msg);
        end

        finish_run();
    end
endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Upstream feeder for the sha256 core. It accepts a message as a byte stream with a valid/ready handshake and applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length. It emits a sequence of 512-bit blocks, each with its own valid/ready handshake. Each block carries first/last flags so the core knows when to load the IV and when the digest is final.

Parameters:
MAX_BYTES, 128, maximum message length in bytes (128 matches the core's 1024-bit message field); bytes beyond this limit are discarded.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  in_data is valid
in_ready  output  1  padder accepts a byte this cycle
in_data  input  8  message byte; the first byte lands in the MSBs of the block
in_last  input  1  current byte is the final byte of the message
blk_valid  output  1  blk_data/blk_first/blk_last are valid
blk_ready  input  1  downstream consumes the block
blk_data  output  512  padded block; bit 511 is the first message bit
blk_first  output  1  block is the first block of the message
blk_last  output  1  block is the final block (holds the length field)
err_ovf  output  1  message exceeded MAX_BYTES

Behaviour:
- Reset (rst_n low at a clk edge): state=FILL, idx=0, bit count=0, all flags cleared, first-pending=1.
  - Outputs while rst_n is low: in_ready=0, blk_valid=0, blk_data=0, blk_first=0, blk_last=0, err_ovf=0.
  - Reset in any state aborts the message; a partially held block is never emitted.
- Internal state:
  - 64-byte buffer and byte index idx (0..63).
  - Bit counter, width clog2(MAX_BYTES+1)+3, zero-extended to 64 bits when written.
  - Flags: msg_done, marker_done, final, first_pending.
- State machine:
  - FILL: in_ready=1. On in_valid&&in_ready, while the byte count is below MAX_BYTES:
    - buf[idx]=in_data; idx++; count+=8.
    - If idx was 63: go to EMIT; set msg_done if in_last.
    - Else if in_last: msg_done=1; go to PAD.
  - FILL, overflow: a byte accepted once MAX_BYTES bytes are held is discarded, with no idx or count change, and err_ovf=1. If that byte has in_last: go to PAD.
  - PAD (1 cycle, in_ready=0):
    - If !marker_done: buf[idx]=0x80 and bytes idx+1..63 are zeroed; marker_done=1. If idx<=55, write the length to bytes 56..63 and set final=1.
    - Else: all bytes are zero, the length goes to bytes 56..63, final=1.
    - Next state is EMIT.
  - EMIT: blk_valid=1, in_ready=0, blk_first=first_pending, blk_last=final.
    - blk_data/blk_first/blk_last stay stable until blk_ready.
    - On blk_ready: clear the buffer, idx=0, first_pending=0.
    - Then: if final, return to FILL with msg_done/marker_done/final/count/err_ovf cleared and first_pending=1. Else if msg_done, go to PAD. Else go to FILL.
- Latency:
  - The 64th byte accepted at edge t gives blk_valid high in cycle t+1.
  - A last byte at idx<63 gives blk_valid in cycle t+2 (one PAD cycle).
- Boundaries:
  - Message of 1..55 bytes: one block.
  - 56..63 bytes: two blocks; the second is all zero plus the length.
  - Exactly 64 bytes: two blocks; the second has 0x80 at byte 0.
- Zero-length messages are not supported (in_last always qualifies a byte).
- err_ovf stays high from the first discarded byte until the final-block handshake.
- The length field reports the bits actually kept, at most MAX_BYTES*8.

Test Plan:
1. "abc" (0x61,0x62,0x63; last on 0x63) -> one block with blk_data = 0x61626380 followed by zeros, low 64 bits = 0x18; blk_first=1, blk_last=1; blk_valid in the 2nd cycle after the last accept.
2. 56 bytes of 0x00 -> block 1: bytes 0..55=0, byte 56=0x80, bytes 57..63=0, first=1, last=0. Block 2: all zero except the low 64 bits = 0x1C0, first=0, last=1.
3. 64 bytes of 0xFF -> block 1 all 0xFF, last=0. Block 2: byte 0=0x80, length field = 0x200, last=1.
4. Backpressure: hold blk_ready=0 for 5 cycles during test 1 -> blk_valid stays high, blk_data stays unchanged, in_ready=0. On release, one transfer occurs and in_ready=1 the next cycle.
5. MAX_BYTES=128 with 130 bytes streamed -> err_ovf rises on byte 129; three blocks are emitted; the final length field = 0x400; err_ovf clears after the final handshake.
6. Assert rst_n=0 for one cycle after 10 bytes of a message -> no block is emitted. The next message "abc" produces exactly the result of test 1 with blk_first=1.
